// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: latch commands, register index and hazard FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'b00,  // load the latch
    PIPE_STALL  = 2'b01,  // hold current contents
    PIPE_NOP    = 2'b10   // load a bubble
  } pipe_state_t;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } hzfsm_t;

  // Load in EX feeding a source of the ID instruction; $0 never creates a hazard.
  function automatic logic load_use(input logic     e_dren,
                                    input regbits_t e_rt,
                                    input regbits_t d_rs,
                                    input regbits_t d_rt,
                                    input logic     d_uses_rt);
    return e_dren && (e_rt != '0) &&
           ((e_rt == d_rs) || (d_uses_rt && (e_rt == d_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, at most one step per cycle.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events until all-ones, then hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         count <= '0;
    else if (inc && (count != '1))   count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: latch commands, PC enable, halt drain and
// stall/flush performance counters.
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             m_dREN,
  input  logic             m_dWEN,
  input  logic             e_dREN,
  input  regbits_t         e_rt,
  input  regbits_t         d_rs,
  input  regbits_t         d_rt,
  input  logic             d_uses_rt,
  input  logic             e_take,
  input  logic             e_halt,
  output pipe_state_t      fd_state,
  output pipe_state_t      de_state,
  output pipe_state_t      em_state,
  output pipe_state_t      mw_state,
  output logic             pc_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  hzfsm_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          halt_q;
  logic          memwait, loaduse;
  logic          stall_inc, flush_inc;

  assign memwait = (m_dREN | m_dWEN) & ~dhit;
  assign loaduse = load_use(e_dREN, e_rt, d_rs, d_rt, d_uses_rt);

  // Priority resolution of latch commands and next FSM state; reset forces bubbles.
  always_comb begin
    fd_state  = PIPE_ENABLE;
    de_state  = PIPE_ENABLE;
    em_state  = PIPE_ENABLE;
    mw_state  = PIPE_ENABLE;
    pc_en     = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_d   = state_q;
    drain_d   = drain_q;
    if (RST) begin
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
      em_state = PIPE_NOP;
      mw_state = PIPE_NOP;
      pc_en    = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (memwait) begin
            // Freeze everything upstream of MEM; a pending branch stays in EX.
            fd_state  = PIPE_STALL;
            de_state  = PIPE_STALL;
            em_state  = PIPE_STALL;
            mw_state  = PIPE_NOP;
            pc_en     = 1'b0;
            stall_inc = 1'b1;
          end else if (e_halt) begin
            // Stop fetching younger work and let older instructions retire.
            fd_state  = PIPE_NOP;
            de_state  = PIPE_NOP;
            pc_en     = 1'b0;
            stall_inc = loaduse | ~ihit;
            state_d   = DRAIN;
            drain_d   = DW'(DRAIN_CYCLES);
          end else if (e_take) begin
            fd_state  = PIPE_NOP;
            de_state  = PIPE_NOP;
            flush_inc = 1'b1;
          end else if (loaduse) begin
            fd_state  = PIPE_STALL;
            de_state  = PIPE_NOP;
            pc_en     = 1'b0;
            stall_inc = 1'b1;
          end else if (!ihit) begin
            fd_state  = PIPE_NOP;
            pc_en     = 1'b0;
            stall_inc = 1'b1;
          end
        end
        DRAIN: begin
          fd_state = PIPE_NOP;
          de_state = PIPE_NOP;
          pc_en    = 1'b0;
          if (memwait) begin
            em_state  = PIPE_STALL;
            mw_state  = PIPE_NOP;
            stall_inc = 1'b1;
          end else begin
            drain_d = drain_q - DW'(1);
            if (drain_q == DW'(1)) state_d = HALTED;
          end
        end
        default: begin
          fd_state = PIPE_NOP;
          de_state = PIPE_NOP;
          em_state = PIPE_NOP;
          mw_state = PIPE_NOP;
          pc_en    = 1'b0;
        end
      endcase
    end
  end

  // FSM, drain counter and sticky halt flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      drain_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      halt_q  <= halt_q | (state_d == HALTED);
    end
  end

  assign halt = halt_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic.
module tb_pipe_hazard_ctrl;

  localparam int DRAIN = 2;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;
  localparam logic [1:0] E = 2'b00, S = 2'b01, N = 2'b10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ihit, dhit, m_dREN, m_dWEN, e_dREN, d_uses_rt, e_take, e_halt;
  logic [4:0]    e_rt, d_rs, d_rt;
  logic [1:0]    fd_state, de_state, em_state, mw_state;
  logic          pc_en, halt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .m_dREN(m_dREN), .m_dWEN(m_dWEN),
    .e_dREN(e_dREN), .e_rt(e_rt), .d_rs(d_rs), .d_rt(d_rt), .d_uses_rt(d_uses_rt),
    .e_take(e_take), .e_halt(e_halt), .fd_state(fd_state), .de_state(de_state),
    .em_state(em_state), .mw_state(mw_state), .pc_en(pc_en), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] fd, de, em, mw;
    logic       pc, hl;
    int         sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: cycles of drain left (0 = not draining), halted flag, counts.
  int m_drain = 0;
  bit m_halted = 0;
  int m_sc = 0, m_fc = 0;

  function automatic void set_cmd(ref exp_t e, input logic [1:0] fd, de, em, mw, input logic pc);
    e.fd = fd; e.de = de; e.em = em; e.mw = mw; e.pc = pc;
  endfunction

  function automatic void bump_stall();
    if (m_sc < SAT) m_sc++;
  endfunction

  // Predict this cycle's outputs from the rules, queue them, then advance the model.
  task automatic push_expect();
    exp_t e;
    bit wt, lu;
    wt = (m_dREN || m_dWEN) && !dhit;
    lu = e_dREN && (e_rt != 0) && ((e_rt == d_rs) || (d_uses_rt && (e_rt == d_rt)));
    e.hl = m_halted; e.sc = m_sc; e.fc = m_fc;
    if (RST) begin
      set_cmd(e, N, N, N, N, 0);
      e.hl = 0; e.sc = 0; e.fc = 0;
      m_drain = 0; m_halted = 0; m_sc = 0; m_fc = 0;
    end else if (m_halted) begin
      set_cmd(e, N, N, N, N, 0);
    end else if (m_drain > 0) begin
      if (wt) begin
        set_cmd(e, N, N, S, N, 0);
        bump_stall();
      end else begin
        set_cmd(e, N, N, E, E, 0);
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end
    end else if (wt) begin
      set_cmd(e, S, S, S, N, 0);
      bump_stall();
    end else if (e_halt) begin
      set_cmd(e, N, N, E, E, 0);
      if (lu || !ihit) bump_stall();
      m_drain = DRAIN;
    end else if (e_take) begin
      set_cmd(e, N, N, E, E, 1);
      if (m_fc < SAT) m_fc++;
    end else if (lu) begin
      set_cmd(e, S, N, E, E, 0);
      bump_stall();
    end else if (!ihit) begin
      set_cmd(e, N, E, E, E, 0);
      bump_stall();
    end else begin
      set_cmd(e, E, E, E, E, 1);
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      vectors++;
      chk("fd_state",  int'(fd_state),  int'(mon_e.fd));
      chk("de_state",  int'(de_state),  int'(mon_e.de));
      chk("em_state",  int'(em_state),  int'(mon_e.em));
      chk("mw_state",  int'(mw_state),  int'(mon_e.mw));
      chk("pc_en",     int'(pc_en),     int'(mon_e.pc));
      chk("halt",      int'(halt),      int'(mon_e.hl));
      chk("stall_cnt", int'(stall_cnt), mon_e.sc);
      chk("flush_cnt", int'(flush_cnt), mon_e.fc);
    end
  end

  task automatic idle();
    RST = 0; ihit = 1; dhit = 1; m_dREN = 0; m_dWEN = 0; e_dREN = 0;
    e_rt = 0; d_rs = 0; d_rt = 0; d_uses_rt = 0; e_take = 0; e_halt = 0;
  endtask

  // Inputs are already set; record the prediction and move to just after the next edge.
  task automatic step();
    push_expect();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle(); RST = 1; step();
    RST = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    #6;
    step();                                   // reset state
    // Reset mid-drain
    idle(); step();
    e_halt = 1; step();
    e_halt = 0; step();
    RST = 1; step();                          // asserted between edges
    idle(); step();
    // Load-use variants
    e_dREN = 1; e_rt = 5; d_rs = 5; step();
    e_rt = 0; step();
    e_rt = 5; d_rs = 3; d_rt = 5; d_uses_rt = 0; step();
    d_uses_rt = 1; step();
    idle(); step();
    // Dmem wait holding a taken branch
    do_reset();
    idle(); m_dREN = 1; dhit = 0; e_take = 1;
    repeat (3) step();
    dhit = 1; step();
    idle(); step();
    // Branch over load-use
    e_take = 1; e_dREN = 1; e_rt = 7; d_rs = 7; step();
    idle(); step();
    // Halt drain with one wait cycle
    e_halt = 1; step();
    idle(); m_dWEN = 1; dhit = 0; step();
    idle(); step();
    step();
    repeat (3) begin
      ihit = 1'($urandom); e_take = 1'($urandom); m_dREN = 1'($urandom); dhit = 1'($urandom);
      step();
    end
    // Stall counter saturation
    do_reset();
    idle(); ihit = 0;
    repeat (20) step();
    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      RST       = ($urandom_range(0, 99) < 2);
      ihit      = ($urandom_range(0, 99) < 75);
      dhit      = ($urandom_range(0, 99) < 60);
      m_dREN    = ($urandom_range(0, 99) < 25);
      m_dWEN    = !m_dREN && ($urandom_range(0, 99) < 15);
      e_dREN    = ($urandom_range(0, 99) < 40);
      e_rt      = 5'($urandom_range(0, 3));
      d_rs      = 5'($urandom_range(0, 3));
      d_rt      = 5'($urandom_range(0, 3));
      d_uses_rt = 1'($urandom);
      e_take    = ($urandom_range(0, 99) < 15);
      e_halt    = !e_take && ($urandom_range(0, 99) < 3);
      step();
    end
    idle(); step();
    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge CLK);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions never checked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
